sprite_cmd_receiver: RTL

- Consumer end of the processor→graphics sprite descriptor interface (valid/ready carrying x, y, frame).
- Accepts descriptors during frame N into a write bank of a double-buffered sprite list.
- Swaps banks on new_frame, then serves the completed list to the rasterizer through an indexed, 1-cycle-latency read port during frame N+1.
- Drives the sprite_ready back-pressure that the processor interface expects.

---
 rtl/sprite_cmd_receiver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sprite_cmd_receiver.sv
// sprite_cmd_receiver
// Receives sprite descriptors over a valid/ready interface into the write bank
// of a double-buffered sprite list. On new_frame the banks swap, and the
// completed list is served to the rasterizer through a 1-cycle read port.
//
// Ports:
//   clk_pixel, sys_rst_n         pixel clock, async active-low reset
//   new_frame                    frame-start pulse (bank swap)
//   sprite_valid/x/y/frame       descriptor input
//   sprite_ready                 registered back-pressure to the producer
//   rd_req, rd_index             rasterizer read request
//   rd_valid, rd_miss, rd_x/y/frame  read response (1 cycle after rd_req)
//   sprite_count                 entries held in the read bank
//   overflow, err_invalid        sticky error flags
module sprite_cmd_receiver #(
  parameter int unsigned CANVAS_WIDTH  = 360,
  parameter int unsigned CANVAS_HEIGHT = 720,
  parameter int unsigned NUM_FRAMES    = 5,
  parameter int unsigned MAX_SPRITES   = 64
) (
  input  logic                              clk_pixel,
  input  logic                              sys_rst_n,
  input  logic                              new_frame,
  input  logic                              sprite_valid,
  input  logic [$clog2(CANVAS_WIDTH)-1:0]   sprite_x,
  input  logic [$clog2(CANVAS_HEIGHT)-1:0]  sprite_y,
  input  logic [$clog2(NUM_FRAMES)-1:0]     sprite_frame,
  output logic                              sprite_ready,
  input  logic                              rd_req,
  input  logic [$clog2(MAX_SPRITES)-1:0]    rd_index,
  output logic                              rd_valid,
  output logic                              rd_miss,
  output logic [$clog2(CANVAS_WIDTH)-1:0]   rd_x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0]  rd_y,
  output logic [$clog2(NUM_FRAMES)-1:0]     rd_frame,
  output logic [$clog2(MAX_SPRITES+1)-1:0]  sprite_count,
  output logic                              overflow,
  output logic                              err_invalid
);

  localparam int unsigned XW = $clog2(CANVAS_WIDTH);
  localparam int unsigned YW = $clog2(CANVAS_HEIGHT);
  localparam int unsigned FW = $clog2(NUM_FRAMES);
  localparam int unsigned IW = $clog2(MAX_SPRITES);
  localparam int unsigned CW = $clog2(MAX_SPRITES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] frame;
  } entry_t;

  // Both banks in one array; the bank select is the top address bit.
  entry_t mem [2*MAX_SPRITES];

  state_t        state, state_next;
  logic [CW-1:0] wr_ptr, wr_ptr_next, count_next;
  logic          wb, wb_next;
  logic          accept, in_range, wr_en, err_set, ovf_set, ready_next;
  logic          rd_hit;
  entry_t        rd_entry;
  entry_t        wr_entry;

  // Range check done at 32 bits so power-of-two limits do not wrap.
  assign in_range = (32'(sprite_x) < CANVAS_WIDTH) &&
                    (32'(sprite_y) < CANVAS_HEIGHT) &&
                    (32'(sprite_frame) < NUM_FRAMES);

  assign wr_entry = '{x: sprite_x, y: sprite_y, frame: sprite_frame};

  // Next-state, write pointer, bank swap and flag-set decisions.
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    count_next  = sprite_count;
    wb_next     = wb;
    ovf_set     = 1'b0;
    accept      = sprite_valid && sprite_ready;
    wr_en       = accept && in_range;
    err_set     = accept && !in_range;

    if (wr_en) wr_ptr_next = wr_ptr + CW'(1);

    unique case (state)
      S_IDLE: begin
        if (new_frame) begin
          state_next = S_ACCEPT;
          count_next = '0;
        end
      end
      S_ACCEPT: begin
        if (wr_en && (wr_ptr_next == CW'(MAX_SPRITES))) state_next = S_FULL;
      end
      S_FULL: begin
        ovf_set = sprite_valid;
      end
      default: state_next = S_IDLE;
    endcase

    // A beat accepted alongside new_frame lands in the old bank and is counted.
    if (new_frame && (state != S_IDLE)) begin
      state_next  = S_ACCEPT;
      count_next  = wr_ptr_next;
      wb_next     = ~wb;
      wr_ptr_next = '0;
    end

    ready_next = (state_next == S_ACCEPT);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      wb           <= 1'b0;
      sprite_count <= '0;
      sprite_ready <= 1'b0;
      overflow     <= 1'b0;
      err_invalid  <= 1'b0;
    end else begin
      state        <= state_next;
      wr_ptr       <= wr_ptr_next;
      wb           <= wb_next;
      sprite_count <= count_next;
      sprite_ready <= ready_next;
      if (ovf_set) overflow    <= 1'b1;
      if (err_set) err_invalid <= 1'b1;
    end
  end

  // Bank storage write; contents are not reset.
  always_ff @(posedge clk_pixel) begin
    if (wr_en) mem[{wb, wr_ptr[IW-1:0]}] <= wr_entry;
  end

  // Read port always addresses the bank not being written.
  assign rd_hit   = (CW'(rd_index) < sprite_count);
  assign rd_entry = mem[{~wb, rd_index}];

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_valid <= 1'b0;
      rd_miss  <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
      rd_frame <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_miss  <= rd_req && !rd_hit;
      if (rd_req) begin
        if (rd_hit) begin
          rd_x     <= rd_entry.x;
          rd_y     <= rd_entry.y;
          rd_frame <= rd_entry.frame;
        end else begin
          rd_x     <= '0;
          rd_y     <= '0;
          rd_frame <= '0;
        end
      end
    end
  end

endmodule
